// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry and scoreboard counter defaults.
package cpu_pkg;

  localparam int NREGS_DEF = 16;
  localparam int CNT_W_DEF = 4;
  localparam int REG_IDX_W = $clog2(NREGS_DEF);

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

endpackage

// File: rtl/sb_counter.sv
// Per-register pending-write counter for the scoreboard.
// Tracks how many in-flight instructions will still write one register.
// A simultaneous increment and decrement cancel out.
// Clear has priority over everything else.
// uflow_o flags a decrement of an empty counter; the counter then stays at zero.
module sb_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o,
  output logic             busy_o,
  output logic             sat_o,
  output logic             uflow_o
);

  logic [CNT_W-1:0] count_q, count_d;

  assign count_o = count_q;
  assign busy_o  = (count_q != '0);
  assign sat_o   = (count_q == '1);
  assign uflow_o = dec_i && !clr_i && (count_q == '0);

  // Next count: clear, else net +1 / -1, holding at both ends of the range
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && !dec_i && !sat_o) begin
      count_d = count_q + CNT_W'(1);
    end else if (dec_i && !inc_i && busy_o) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Counter register with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard.
// Counts the pending writes for every architectural register.
// Stalls decode on a read-after-write hazard or when a counter is full.
// Register 0 is hardwired and never tracked.
// Optional feature: define RETIRE_BYPASS_EN to let a source whose only pending
// writer retires this cycle proceed without stalling.
module reg_scoreboard
  import cpu_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int NREGS = NREGS_DEF,
  localparam int IDX_W = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  input  logic             issue_writes,
  input  logic [IDX_W-1:0] issue_rt,
  input  logic             src0_valid,
  input  logic [IDX_W-1:0] src0_idx,
  input  logic             src1_valid,
  input  logic [IDX_W-1:0] src1_idx,
  input  logic             retire_valid,
  input  logic             retire_writes,
  input  logic [IDX_W-1:0] retire_rt,
  input  logic             flush,
  output logic             stall,
  output logic [NREGS-1:0] busy_mask,
  output logic             underflow_err
);

  logic [NREGS-1:0] busyVec, satVec, uflowVec;
  logic [CNT_W-1:0] cnt [NREGS];
  logic             accept;
  logic             src0Block, src1Block;
  logic             underflow_q, underflow_d;

  assign accept        = issue_valid && !stall && !flush;
  assign busy_mask     = busyVec;
  assign underflow_err = underflow_q;

  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    if (i == 0) begin : g_zero
      assign cnt[i]      = '0;
      assign busyVec[i]  = 1'b0;
      assign satVec[i]   = 1'b0;
      assign uflowVec[i] = 1'b0;
    end else begin : g_track
      sb_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_i  (accept && issue_writes && (issue_rt == IDX_W'(i))),
        .dec_i  (retire_valid && retire_writes && !flush && (retire_rt == IDX_W'(i))),
        .clr_i  (flush),
        .count_o(cnt[i]),
        .busy_o (busyVec[i]),
        .sat_o  (satVec[i]),
        .uflow_o(uflowVec[i])
      );
    end
  end

  // Hazard detection from the current counters; flush does not affect it
  always_comb begin
    src0Block = src0_valid && busyVec[src0_idx];
    src1Block = src1_valid && busyVec[src1_idx];
`ifdef RETIRE_BYPASS_EN
    if (retire_valid && retire_writes && !flush) begin
      if ((retire_rt == src0_idx) && (cnt[src0_idx] == CNT_W'(1))) begin
        src0Block = 1'b0;
      end
      if ((retire_rt == src1_idx) && (cnt[src1_idx] == CNT_W'(1))) begin
        src1Block = 1'b0;
      end
    end
`endif
    stall = issue_valid && (src0Block || src1Block || (issue_writes && satVec[issue_rt]));
  end

  // Underflow is sticky: once any counter reports one, the flag holds until reset
  always_comb begin
    underflow_d = underflow_q | (|uflowVec);
  end

  // Sticky error register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow_q <= 1'b0;
    end else begin
      underflow_q <= underflow_d;
    end
  end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have parameter CNT_W, default 4: width of each per-register pending-write counter.
REQ-002 SHALL have parameter NREGS, default 16: number of architectural registers; index width is log2(NREGS).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 issue_valid  input  1  decode presents an instruction this cycle.
REQ-006 issue_writes  input  1  the presented instruction writes a register (sub, movl, movh, ld).
REQ-007 issue_rt  input  4  destination register of the presented instruction.
REQ-008 src0_valid / src1_valid  input  1 each  source operand in use.
REQ-009 src0_idx / src1_idx  input  4 each  source register indices (ra/rt or rb/rt, as chosen by decode).
REQ-010 retire_valid  input  1  execute stage completes a valid instruction this cycle.
REQ-011 retire_writes  input  1  the retiring instruction wrote a register.
REQ-012 retire_rt  input  4  destination register of the retiring instruction.
REQ-013 flush  input  1  taken-branch redirect; all in-flight instructions are discarded.
REQ-014 stall  output  1  combinational; decode SHALL hold its instruction.
REQ-015 busy_mask  output  NREGS  bit i high when counter i is non-zero.
REQ-016 underflow_err  output  1  sticky error flag.

Function
REQ-017 Register 0 SHALL never be tracked: its counter is constantly 0 and it never causes a stall.
REQ-018 stall SHALL be high when issue_valid and (src0_valid and count[src0_idx]!=0, or src1_valid and count[src1_idx]!=0, or issue_writes and count[issue_rt]==2^CNT_W-1).
REQ-019 An issue is accepted when issue_valid and !stall and !flush.
REQ-020 An accepted issue with issue_writes and issue_rt!=0 SHALL increment count[issue_rt] at the next edge (1-cycle latency).
REQ-021 retire_valid and retire_writes and retire_rt!=0 and !flush SHALL decrement count[retire_rt] at the next edge.
REQ-022 Issue and retire to the same register in the same cycle SHALL leave that counter unchanged.
REQ-023 Retire to a register whose counter is 0 SHALL leave it at 0 and set underflow_err.
REQ-024 flush SHALL clear all counters to 0 at the next edge; issue and retire in the flush cycle are ignored.
REQ-025 stall SHALL be evaluated from current counters; flush does not force stall.
REQ-026 busy_mask SHALL be combinational from the counters.
REQ-027 underflow_err SHALL remain set until reset.

Reset
REQ-028 rst_n low SHALL asynchronously clear all counters and underflow_err; busy_mask=0 and stall=0 while in reset.
REQ-029 Deassertion SHALL take effect at the first rising edge after rst_n goes high.

Configuration
REQ-030 With RETIRE_BYPASS_EN defined, a source match SHALL not stall when count==1 and the same register is retiring (retire_valid, retire_writes, retire_rt==idx, !flush) in the current cycle.
REQ-031 Without RETIRE_BYPASS_EN, any non-zero source counter SHALL stall regardless of a same-cycle retire.

Structure
REQ-032 Shared package cpu_pkg SHALL hold the register-index width, NREGS default, CNT_W default and the reg_idx_t typedef.
REQ-033 Per-register counter with inc/dec/clear/saturation flag SHALL be a sub-module sb_counter, instantiated NREGS-1 times.

Verification
REQ-034 Issue writes r3, then issue a src0=r3 reader next cycle -> stall=1, busy_mask=16'h0008; retire r3 -> stall=0 the following cycle.
REQ-035 Issue writes r0 with src r0 -> stall=0, busy_mask stays 16'h0000.
REQ-036 15 accepted issues to r5 with no retire -> count[5]=15; a 16th issue to r5 -> stall=1, count unchanged.
REQ-037 count[2]=1, issue r2 and retire r2 in the same cycle -> count[2]=1 after the edge.
REQ-038 Counters r1=2 and r4=1, pulse flush together with a retire of r1 -> busy_mask=16'h0000 after one edge, underflow_err=0.
REQ-039 Retire r7 at count 0 -> underflow_err=1 and held; rst_n low mid-run -> all outputs 0 immediately; with RETIRE_BYPASS_EN, count[6]=1, src0=r6 while r6 retires -> stall=0.
